// File: rtl/lsu_apb_bridge.sv
// LSU front end: dmem passthrough plus APB3 master for the peripheral window.
// Stalls the pipeline while an APB transfer is in flight; aborts on timeout.
module lsu_apb_bridge #(
    parameter logic [31:0] PERIPH_BASE = 32'h1000_0000,
    parameter logic [31:0] PERIPH_MASK = 32'hF000_0000,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_lsu_op,
    output logic        o_stall,
    output logic [31:0] o_rdata,
    output logic        o_err,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_bmask,
    output logic        o_dmem_wren,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_psel,
    output logic        o_penable,
    output logic        o_pwrite,
    output logic [31:0] o_paddr,
    output logic [31:0] o_pwdata,
    output logic [3:0]  o_pstrb,
    input  logic        i_pready,
    input  logic        i_pslverr,
    input  logic [31:0] i_prdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_DONE
    } state_e;

    state_e          state_q;
    logic            psel_q;
    logic            penable_q;
    logic            pwrite_q;
    logic [31:0]     paddr_q;
    logic [31:0]     pwdata_q;
    logic [3:0]      pstrb_q;
    logic [3:0]      op_q;
    logic [1:0]      lane_q;
    logic [31:0]     prdata_q;
    logic            pslverr_q;
    logic            tout_q;
    logic [CW-1:0]   wait_q;

    logic        is_ld;
    logic        is_st;
    logic        is_half;
    logic        is_word;
    logic        act;
    logic        misal;
    logic        periph;
    logic        idle;
    logic        launch;
    logic        done_err;
    logic [31:0] st_data;
    logic [3:0]  st_strb;
    logic [15:0] sh;
    logic [31:0] ld_data;

    // Classify the MEM-stage op; unknown codes decode to nothing.
    always_comb begin
        is_ld   = 1'b0;
        is_st   = 1'b0;
        is_half = 1'b0;
        is_word = 1'b0;
        case (i_lsu_op)
            4'b0000, 4'b0001: is_ld = 1'b1;
            4'b0010, 4'b0011: begin
                is_ld   = 1'b1;
                is_half = 1'b1;
            end
            4'b0100: begin
                is_ld   = 1'b1;
                is_word = 1'b1;
            end
            4'b1000: is_st = 1'b1;
            4'b1001: begin
                is_st   = 1'b1;
                is_half = 1'b1;
            end
            4'b1010: begin
                is_st   = 1'b1;
                is_word = 1'b1;
            end
            default: ;
        endcase
    end

    assign act      = i_req & (is_ld | is_st) & ~i_reset;
    assign misal    = (is_half & i_addr[0]) | (is_word & (|i_addr[1:0]));
    assign periph   = (i_addr & PERIPH_MASK) == PERIPH_BASE;
    assign idle     = state_q == S_IDLE;
    assign launch   = idle & act & ~misal & periph;
    assign done_err = pslverr_q | tout_q;

    // Replicate store data across lanes and build the byte strobe.
    always_comb begin
        st_data = '0;
        st_strb = '0;
        if (is_st) begin
            if (is_word) begin
                st_data = i_wdata;
                st_strb = 4'b1111;
            end else if (is_half) begin
                st_data = {2{i_wdata[15:0]}};
                st_strb = 4'b0011 << i_addr[1:0];
            end else begin
                st_data = {4{i_wdata[7:0]}};
                st_strb = 4'b0001 << i_addr[1:0];
            end
        end
    end

    // Pick the addressed byte/half from the captured word and extend it.
    always_comb begin
        sh = 16'(prdata_q >> {lane_q, 3'b000});
        case (op_q)
            4'b0000: ld_data = {{24{sh[7]}}, sh[7:0]};
            4'b0001: ld_data = {24'h0, sh[7:0]};
            4'b0010: ld_data = {{16{sh[15]}}, sh};
            4'b0011: ld_data = {16'h0, sh};
            4'b0100: ld_data = prdata_q;
            default: ld_data = '0;
        endcase
    end

    // Load result: dmem passthrough in IDLE, extracted APB data in DONE.
    always_comb begin
        o_rdata = '0;
        if (!i_reset) begin
            if (idle && !periph && !(act && misal)) begin
                o_rdata = i_dmem_rdata;
            end else if (state_q == S_DONE && !done_err) begin
                o_rdata = ld_data;
            end
        end
    end

    assign o_stall = ~i_reset &
                     (launch | (state_q == S_SETUP) | (state_q == S_ACCESS));
    assign o_err   = ~i_reset &
                     ((idle & act & misal) | ((state_q == S_DONE) & done_err));

    assign o_dmem_addr  = i_addr;
    assign o_dmem_wdata = i_wdata;
    assign o_dmem_bmask = i_lsu_op;
    assign o_dmem_wren  = idle & act & ~misal & ~periph & is_st;

    assign o_psel    = psel_q;
    assign o_penable = penable_q;
    assign o_pwrite  = pwrite_q;
    assign o_paddr   = paddr_q;
    assign o_pwdata  = pwdata_q;
    assign o_pstrb   = pstrb_q;

    // APB transfer sequencer with registered bus outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            op_q      <= '0;
            lane_q    <= '0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            tout_q    <= 1'b0;
            wait_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (launch) begin
                        state_q   <= S_SETUP;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        pwrite_q  <= is_st;
                        paddr_q   <= {i_addr[31:2], 2'b00};
                        pwdata_q  <= st_data;
                        pstrb_q   <= st_strb;
                        op_q      <= i_lsu_op;
                        lane_q    <= i_addr[1:0];
                        pslverr_q <= 1'b0;
                        tout_q    <= 1'b0;
                        wait_q    <= '0;
                    end
                end
                S_SETUP: begin
                    state_q   <= S_ACCESS;
                    penable_q <= 1'b1;
                end
                S_ACCESS: begin
                    if (i_pready) begin
                        state_q   <= S_DONE;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        prdata_q  <= i_prdata;
                        pslverr_q <= i_pslverr;
                    end else if (wait_q == CW'(TIMEOUT - 1)) begin
                        state_q   <= S_DONE;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        tout_q    <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_apb_bridge.sv
// Bench for lsu_apb_bridge: driver pushes expected results to a scoreboard,
// a negedge monitor pops them when the bridge releases the stall.
module tb_lsu_apb_bridge;

    logic        i_clk;
    logic        i_reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [3:0]  i_lsu_op;
    logic        o_stall;
    logic [31:0] o_rdata;
    logic        o_err;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic [3:0]  o_dmem_bmask;
    logic        o_dmem_wren;
    logic [31:0] i_dmem_rdata;
    logic        o_psel;
    logic        o_penable;
    logic        o_pwrite;
    logic [31:0] o_paddr;
    logic [31:0] o_pwdata;
    logic [3:0]  o_pstrb;
    logic        i_pready;
    logic        i_pslverr;
    logic [31:0] i_prdata;

    lsu_apb_bridge dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .i_lsu_op     (i_lsu_op),
        .o_stall      (o_stall),
        .o_rdata      (o_rdata),
        .o_err        (o_err),
        .o_dmem_addr  (o_dmem_addr),
        .o_dmem_wdata (o_dmem_wdata),
        .o_dmem_bmask (o_dmem_bmask),
        .o_dmem_wren  (o_dmem_wren),
        .i_dmem_rdata (i_dmem_rdata),
        .o_psel       (o_psel),
        .o_penable    (o_penable),
        .o_pwrite     (o_pwrite),
        .o_paddr      (o_paddr),
        .o_pwdata     (o_pwdata),
        .o_pstrb      (o_pstrb),
        .i_pready     (i_pready),
        .i_pslverr    (i_pslverr),
        .i_prdata     (i_prdata)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          stalls;
        logic        wren;
    } exp_t;

    typedef struct {
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
        logic        pwrite;
    } apb_t;

    exp_t sb_q[$];
    apb_t apb_q[$];
    apb_t last_apb;

    int n_chk = 0;
    int n_pass = 0;
    int stall_cnt = 0;

    int          wait_n = 0;
    logic        slverr_v = 1'b0;
    logic [31:0] prdata_v = '0;
    logic        hang_v = 1'b0;
    int          acc_cnt = 0;

    logic [31:0] mem [0:63];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic apb_t apb_model(input logic [31:0] addr,
                                       input logic [31:0] wdata,
                                       input logic [3:0] op);
        apb_t a;
        a.paddr  = addr & 32'hFFFF_FFFC;
        a.pwrite = op[3];
        case (op)
            4'b1000: begin
                a.pwdata = {4{wdata[7:0]}};
                a.pstrb  = 4'(1 << addr[1:0]);
            end
            4'b1001: begin
                a.pwdata = {2{wdata[15:0]}};
                a.pstrb  = 4'(3 << addr[1:0]);
            end
            4'b1010: begin
                a.pwdata = wdata;
                a.pstrb  = 4'hF;
            end
            default: begin
                a.pwdata = '0;
                a.pstrb  = 4'h0;
            end
        endcase
        return a;
    endfunction

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    assign i_dmem_rdata = mem[o_dmem_addr[7:2]];

    // Word-wide data memory model.
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        forever begin
            @(posedge i_clk);
            if (o_dmem_wren) mem[o_dmem_addr[7:2]] = o_dmem_wdata;
        end
    end

    // APB slave: PREADY rises after wait_n low ACCESS cycles.
    initial begin
        i_pready  = 1'b0;
        i_pslverr = 1'b0;
        i_prdata  = '0;
        forever begin
            @(negedge i_clk);
            if (o_psel && o_penable) acc_cnt++;
            else acc_cnt = 0;
            i_pready  = o_psel && o_penable && !hang_v && (acc_cnt > wait_n);
            i_pslverr = i_pready && slverr_v;
            i_prdata  = prdata_v;
        end
    end

    // Monitor: APB setup/hold checks and scoreboard compare on completion.
    initial begin
        exp_t e;
        apb_t a;
        forever begin
            @(negedge i_clk);
            if (i_reset) begin
                stall_cnt = 0;
            end else begin
                if (o_psel && !o_penable) begin
                    if (apb_q.size() == 0) begin
                        chk("apb_unexp", 32'd1, 32'd0);
                    end else begin
                        a = apb_q.pop_front();
                        chk("paddr", o_paddr, a.paddr);
                        chk("pstrb", {28'h0, o_pstrb}, {28'h0, a.pstrb});
                        chk("pwrite", {31'h0, o_pwrite}, {31'h0, a.pwrite});
                        if (a.pwrite) chk("pwdata", o_pwdata, a.pwdata);
                        last_apb = a;
                    end
                end
                if (o_psel && o_penable) begin
                    chk("paddr_hold", o_paddr, last_apb.paddr);
                    chk("pstrb_hold", {28'h0, o_pstrb}, {28'h0, last_apb.pstrb});
                end
                if (i_req) begin
                    if (o_stall) begin
                        stall_cnt++;
                        chk("wren_stall", {31'h0, o_dmem_wren}, 32'd0);
                    end else begin
                        if (sb_q.size() == 0) begin
                            chk("sb_unexp", 32'd1, 32'd0);
                        end else begin
                            e = sb_q.pop_front();
                            chk("rdata", o_rdata, e.rdata);
                            chk("err", {31'h0, o_err}, {31'h0, e.err});
                            chk("stalls", stall_cnt, e.stalls);
                            chk("wren", {31'h0, o_dmem_wren}, {31'h0, e.wren});
                            chk("psel_done", {31'h0, o_psel}, 32'd0);
                        end
                        stall_cnt = 0;
                    end
                end
            end
        end
    end

    task automatic issue(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] op, input int waits,
                         input logic serr, input logic [31:0] prd,
                         input logic hang, input logic [31:0] x_rdata,
                         input logic x_err, input int x_stalls,
                         input logic x_wren);
        exp_t e;
        bit   done = 1'b0;
        wait_n   = waits;
        slverr_v = serr;
        prdata_v = prd;
        hang_v   = hang;
        i_req    = 1'b1;
        i_addr   = addr;
        i_wdata  = wdata;
        i_lsu_op = op;
        e.rdata  = x_rdata;
        e.err    = x_err;
        e.stalls = x_stalls;
        e.wren   = x_wren;
        sb_q.push_back(e);
        if (x_stalls > 0) apb_q.push_back(apb_model(addr, wdata, op));
        for (int k = 0; k < 100; k++) begin
            @(negedge i_clk);
            if (!o_stall) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("drv_bound", 32'd0, 32'd1);
        @(posedge i_clk);
        #1;
        i_req = 1'b0;
    endtask

    initial begin
        bit seen;
        i_reset  = 1'b1;
        i_req    = 1'b0;
        i_addr   = '0;
        i_wdata  = '0;
        i_lsu_op = '0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_psel", {31'h0, o_psel}, 32'd0);
        chk("rst_penable", {31'h0, o_penable}, 32'd0);
        chk("rst_stall", {31'h0, o_stall}, 32'd0);
        chk("rst_err", {31'h0, o_err}, 32'd0);
        chk("rst_rdata", o_rdata, 32'd0);
        chk("rst_pstrb", {28'h0, o_pstrb}, 32'd0);
        chk("rst_paddr", o_paddr, 32'd0);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        @(posedge i_clk);
        #1;

        // dmem store then load
        issue(32'h40, 32'hCAFE_BABE, 4'b1010, 0, 0, 0, 0,
              32'h0, 0, 0, 1);
        issue(32'h40, 32'h0, 4'b0100, 0, 0, 0, 0,
              32'hCAFE_BABE, 0, 0, 0);
        // APB byte store, zero waits
        issue(32'h1000_0003, 32'h0000_00A5, 4'b1000, 0, 0, 0, 0,
              32'h0, 0, 3, 0);
        // APB half loads with two wait states
        issue(32'h1000_0002, 32'h0, 4'b0010, 2, 0, 32'h8001_1234, 0,
              32'hFFFF_8001, 0, 5, 0);
        issue(32'h1000_0002, 32'h0, 4'b0011, 2, 0, 32'h8001_1234, 0,
              32'h0000_8001, 0, 5, 0);
        // byte loads, lane selection and extension
        issue(32'h1000_0001, 32'h0, 4'b0000, 0, 0, 32'h8001_1234, 0,
              32'h0000_0012, 0, 3, 0);
        issue(32'h1000_0003, 32'h0, 4'b0000, 1, 0, 32'h8001_1234, 0,
              32'hFFFF_FF80, 0, 4, 0);
        issue(32'h1000_0003, 32'h0, 4'b0001, 0, 0, 32'h8001_1234, 0,
              32'h0000_0080, 0, 3, 0);
        // half store to upper lane
        issue(32'h1000_0006, 32'h0000_BEEF, 4'b1001, 0, 0, 0, 0,
              32'h0, 0, 3, 0);
        // slave error
        issue(32'h1000_0000, 32'h0, 4'b0100, 0, 1, 32'h1234_5678, 0,
              32'h0, 1, 3, 0);
        // timeout then a normal back-to-back store and load
        issue(32'h1000_0010, 32'h0, 4'b0100, 0, 0, 32'h5555_5555, 1,
              32'h0, 1, 18, 0);
        issue(32'h1000_0014, 32'h1234_5678, 4'b1010, 0, 0, 0, 0,
              32'h0, 0, 3, 0);
        issue(32'h1000_0014, 32'h0, 4'b0100, 0, 0, 32'h7654_3210, 0,
              32'h7654_3210, 0, 3, 0);
        // misaligned: peripheral word, dmem half store
        issue(32'h1000_0002, 32'h0, 4'b0100, 0, 0, 0, 0,
              32'h0, 1, 0, 0);
        issue(32'h0000_0041, 32'hFFFF, 4'b1001, 0, 0, 0, 0,
              32'h0, 1, 0, 0);
        issue(32'h40, 32'h0, 4'b0100, 0, 0, 0, 0,
              32'hCAFE_BABE, 0, 0, 0);

        // reset while in ACCESS abandons the transfer silently
        hang_v   = 1'b1;
        i_req    = 1'b1;
        i_addr   = 32'h1000_0020;
        i_wdata  = '0;
        i_lsu_op = 4'b0100;
        apb_q.push_back(apb_model(32'h1000_0020, 32'h0, 4'b0100));
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge i_clk);
            if (o_psel && o_penable) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rst_reach_access", {31'h0, seen}, 32'd1);
        #1;
        i_reset = 1'b1;
        i_req   = 1'b0;
        @(negedge i_clk);
        chk("rst_acc_psel", {31'h0, o_psel}, 32'd0);
        chk("rst_acc_penable", {31'h0, o_penable}, 32'd0);
        chk("rst_acc_err", {31'h0, o_err}, 32'd0);
        #1;
        i_reset = 1'b0;
        hang_v  = 1'b0;
        @(negedge i_clk);
        chk("post_rst_psel", {31'h0, o_psel}, 32'd0);
        chk("post_rst_err", {31'h0, o_err}, 32'd0);
        chk("post_rst_stall", {31'h0, o_stall}, 32'd0);
        @(posedge i_clk);
        #1;
        issue(32'h1000_0008, 32'h0, 4'b0100, 0, 0, 32'h0BAD_F00D, 0,
              32'h0BAD_F00D, 0, 3, 0);

        repeat (3) @(posedge i_clk);
        chk("sb_empty", sb_q.size(), 32'd0);
        chk("apb_empty", apb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lsu_apb_bridge.md
# lsu_apb_bridge

Load/store front end sitting between the pipeline MEM stage and the data memory / APB peripheral bus. Decodes each MEM-stage access by address: data-memory accesses pass straight through to `dmem` with zero added latency, while peripheral accesses are launched as APB3 transfers while the pipeline is stalled. Performs byte-lane steering, strobe generation, load sign/zero extension for APB reads, misalignment checks and an APB timeout.

## Interface
- PERIPH_BASE, 32'h1000_0000: base of the peripheral region.
- PERIPH_MASK, 32'hF000_0000: an address is a peripheral access when (i_addr & PERIPH_MASK) == PERIPH_BASE; otherwise it is a dmem access.
- TIMEOUT, 16: maximum number of ACCESS cycles with PREADY low before the transfer is aborted.

- i_clk  in  1  clock
- i_reset  in  1  reset i_reset, synchronous, active-high; clock i_clk
- i_req  in  1  MEM stage holds a valid load/store
- i_addr  in  32  byte address
- i_wdata  in  32  store data, right-aligned
- i_lsu_op  in  4  0000 LB, 0001 LBU, 0010 LH, 0011 LHU, 0100 LW, 1000 SB, 1001 SH, 1010 SW; other codes are no-ops
- o_stall  out  1  freezes the pipeline at and before MEM
- o_rdata  out  32  load result to writeback
- o_err  out  1  one-cycle pulse on a misaligned access, PSLVERR or timeout
- o_dmem_addr / o_dmem_wdata  out  32 each  passthrough of i_addr / i_wdata
- o_dmem_bmask  out  4  passthrough of i_lsu_op
- o_dmem_wren  out  1  dmem write enable
- i_dmem_rdata  in  32  dmem load result, already extended
- o_psel, o_penable, o_pwrite  out  1 each  APB control
- o_paddr  out  32  word-aligned APB address ({addr[31:2],2'b00})
- o_pwdata  out  32  store data replicated across lanes: SB {4{b}}, SH {2{h}}, SW as-is
- o_pstrb  out  4  SB 0001<<addr[1:0]; SH 0011<<addr[1:0]; SW 1111; loads 0000
- i_pready, i_pslverr  in  1 each  APB slave response
- i_prdata  in  32  APB read data

## Operation
- The FSM has four states: IDLE, SETUP, ACCESS, DONE. All outputs are 0 on reset; the held read-data register is 0 on reset.
- Misaligned access: LH, LHU or SH with addr[0]=1, or LW or SW with addr[1:0]≠0. It is detected in IDLE for both regions.
  - No dmem write and no APB transfer take place.
  - o_err pulses for that cycle and o_rdata = 0.
  - There is no stall.
- Dmem access, aligned, in IDLE:
  - o_dmem_wren = i_req & i_lsu_op[3].
  - o_rdata = i_dmem_rdata.
  - o_stall = 0.
- Peripheral access, aligned, in IDLE:
  - o_stall = 1 combinationally.
  - addr, wdata, op and lane are registered, and the FSM moves to SETUP.
  - o_dmem_wren = 0.
- SETUP: psel=1, penable=0, with the registered address, data and strobe. The FSM always moves to ACCESS next.
- ACCESS: psel=1, penable=1.
  - If i_pready=1, capture i_prdata and i_pslverr and go to DONE.
  - If i_pready=0, increment the wait counter. On reaching TIMEOUT, go to DONE with a timeout flag.
- DONE: psel=0, o_stall=0.
  - o_rdata = the extracted load result: the byte or half is selected from the captured word by the registered addr[1:0], then sign- or zero-extended per op. Stores give 0.
  - If the slave returned PSLVERR or the transfer timed out, o_err=1 and o_rdata=0.
  - The FSM goes to IDLE. The i_req seen in DONE is the completed request and is not relaunched.
- APB signals are held stable from SETUP through ACCESS until PREADY is sampled.
- Reset in any state takes effect at the next edge: FSM to IDLE, psel and penable low, counter cleared. An abandoned transfer produces no o_err.

## Timing
- Dmem accesses add no cycles: combinational passthrough, and the write happens at the dmem clock edge.
- Peripheral request first seen in cycle N, with zero wait states:
  - N: IDLE, stall=1.
  - N+1: SETUP.
  - N+2: ACCESS, with PREADY sampled at the end of N+2.
  - N+3: DONE, stall=0, the pipeline advances.
  - This is 3 stall cycles in total. Each PREADY-low cycle adds one more.
- Timeout: DONE is entered after exactly TIMEOUT ACCESS cycles with PREADY low.
- A new request is accepted in the cycle after DONE, so back-to-back peripheral accesses are 4 cycles apart with zero wait states.
- The upstream stage holds i_req, i_addr, i_wdata and i_lsu_op stable while o_stall=1. The bridge uses only its registered copies after IDLE.

## Test plan
- SW to 0x0000_0040 with data 0xCAFEBABE, then LW from 0x40 → o_dmem_wren=1 for one cycle, o_stall is never asserted, o_rdata=0xCAFEBABE.
- SB to 0x1000_0003 with data 0x000000A5, PREADY held high → SETUP then ACCESS, paddr=0x1000_0000, pwdata=0xA5A5A5A5, pstrb=1000, pwrite=1, stall for exactly 3 cycles.
- LH from 0x1000_0002 with prdata=0x8001_1234 and 2 wait states → stall for 5 cycles, o_rdata=0xFFFF8001 in DONE. Repeat as LHU → 0x00008001.
- LW from 0x1000_0000 with PREADY=1 and PSLVERR=1 → o_err pulses in DONE, o_rdata=0.
- PREADY held low with TIMEOUT=16 → exactly 16 ACCESS cycles, then DONE with o_err=1 and psel dropping. The following request proceeds normally.
- LW from 0x1000_0002 → o_err pulses in the same cycle, no psel, no stall. Separately, asserting i_reset during ACCESS → psel=0 and state IDLE after the next edge, with no o_err.
